// File: rtl/lsu.sv
// Load/store and writeback staging for the RV32I pipeline: performs one bus access per
// load/store, steers byte lanes, extends load data and presents one writeback per instruction.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [16:0] full_op,
    input  logic [31:0] alu_value,
    input  logic [31:0] store_data,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_value,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [1:0]  out_exc
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    // The counter holds completed wait cycles, so the last allowed cycle is one below the limit.
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [31:0] addr_reg, addr_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] out_value_reg, out_value_next;
    logic [4:0]  out_rd_reg, out_rd_next;
    logic        out_we_reg, out_we_next;
    logic [1:0]  out_exc_reg, out_exc_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        unused_funct7;
    logic        is_load, is_store, f3_legal, misaligned, accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    assign opcode        = full_op[6:0];
    assign funct3        = full_op[9:7];
    assign unused_funct7 = ^full_op[16:10];

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mem_req   = (state_reg == MEM);
    assign out_valid = (state_reg == DONE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_wdata = mem_wdata_reg;
    assign out_value = out_value_reg;
    assign out_rd    = out_rd_reg;
    assign out_we    = out_we_reg;
    assign out_exc   = out_exc_reg;

    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        f3_legal   = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = alu_value[0];
            2'b10:   misaligned = (alu_value[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Lane selection uses the address captured at accept, not the live input.
    always_comb begin
        byte_sel = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
        half_sel = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'd0, byte_sel};
            3'b101:  load_value = {16'd0, half_sel};
            default: load_value = mem_rdata;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        funct3_next    = funct3_reg;
        addr_next      = addr_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wstrb_next = mem_wstrb_reg;
        mem_wdata_next = mem_wdata_reg;
        out_value_next = out_value_reg;
        out_rd_next    = out_rd_reg;
        out_we_next    = out_we_reg;
        out_exc_next   = out_exc_reg;

        case (state_reg)
            MEM: begin
                if (mem_ack) begin
                    state_next     = DONE;
                    out_exc_next   = EXC_NONE;
                    out_value_next = mem_we_reg ? addr_reg : load_value;
                    out_we_next    = !mem_we_reg && (out_rd_reg != 5'd0);
                end else if (count_reg == COUNT_LAST) begin
                    state_next     = DONE;
                    out_exc_next   = EXC_TIMEOUT;
                    out_value_next = addr_reg;
                    out_we_next    = 1'b0;
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new accept overrides the retire-to-IDLE path above.
        if (accept) begin
            count_next     = 16'd0;
            funct3_next    = funct3;
            addr_next      = alu_value;
            out_rd_next    = rd_in;
            out_value_next = alu_value;
            out_exc_next   = EXC_NONE;
            out_we_next    = (rd_in != 5'd0);
            state_next     = DONE;
            if (is_load || is_store) begin
                out_we_next = 1'b0;
                if (!f3_legal) begin
                    out_exc_next = EXC_ILLEGAL;
                end else if (misaligned) begin
                    out_exc_next = EXC_MISALIGN;
                end else begin
                    state_next     = MEM;
                    mem_we_next    = is_store;
                    mem_addr_next  = {alu_value[31:2], 2'b00};
                    mem_wstrb_next = 4'b0000;
                    mem_wdata_next = 32'd0;
                    if (is_store) begin
                        case (funct3[1:0])
                            2'b00: begin
                                mem_wstrb_next = 4'b0001 << alu_value[1:0];
                                mem_wdata_next = {4{store_data[7:0]}};
                            end
                            2'b01: begin
                                mem_wstrb_next = 4'b0011 << alu_value[1:0];
                                mem_wdata_next = {2{store_data[15:0]}};
                            end
                            default: begin
                                mem_wstrb_next = 4'b1111;
                                mem_wdata_next = store_data;
                            end
                        endcase
                    end
                end
            end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                out_value_next = pc_plus4;
            end else if (opcode == OP_BRANCH) begin
                out_we_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 16'd0;
            funct3_reg    <= 3'd0;
            addr_reg      <= 32'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wstrb_reg <= 4'd0;
            mem_wdata_reg <= 32'd0;
            out_value_reg <= 32'd0;
            out_rd_reg    <= 5'd0;
            out_we_reg    <= 1'b0;
            out_exc_reg   <= 2'd0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            funct3_reg    <= funct3_next;
            addr_reg      <= addr_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_wdata_reg <= mem_wdata_next;
            out_value_reg <= out_value_next;
            out_rd_reg    <= out_rd_next;
            out_we_reg    <= out_we_next;
            out_exc_reg   <= out_exc_next;
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store and writeback-staging unit sitting directly downstream of the ALU in the RV32I datapath. Takes the decoded 17-bit op, the ALU result and the store operand; performs the data-memory access for loads and stores over a request/acknowledge bus, and presents a single register-writeback result for every instruction. Handles byte/halfword lane steering, sign/zero extension, misalignment detection and bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: cycles `mem_req` may stay high without `mem_ack` before a bus error is raised (1..65535).
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- full_op  in  17  {funct7[16:10], funct3[9:7], opcode[6:0]}
- alu_value  in  32  ALU result; effective address for loads/stores
- store_data  in  32  rs2 value for stores
- pc_plus4  in  32  link value for jal/jalr
- rd_in  in  5  destination register
- mem_req  out  1  bus request, held until acknowledged
- mem_we  out  1  1 = write
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_wstrb  out  4  byte enables for writes (0 on reads)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  request completed this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- out_valid  out  1  writeback result available
- out_ready  in  1  downstream consumes; transfer when out_valid && out_ready
- out_value  out  32  writeback value
- out_rd  out  5  writeback register
- out_we  out  1  register write enable
- out_exc  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3

## Operation
- States: IDLE, MEM, DONE. Reset → IDLE; all outputs 0.
- in_ready = (IDLE) or (DONE and out_ready). Accept in DONE overlaps retirement.
- On accept, by opcode:
  - 0000011 load: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other funct3 → exc 11.
  - 0100011 store: funct3 000 sb, 001 sh, 010 sw; other → exc 11.
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0 → exc 01.
  - Valid load/store → MEM. Exception → DONE, out_we=0, no bus activity, out_value = alu_value.
  - 1101111/1100111 (jal/jalr): DONE, out_value=pc_plus4, out_we=1.
  - 1100011 (branch): DONE, out_we=0.
  - All other opcodes: DONE, out_value=alu_value, out_we=1.
- out_we forced 0 when rd_in=0.
- Store: off=addr[1:0]; sb wstrb=0001<<off, wdata={4{store_data[7:0]}}; sh wstrb=0011<<off, wdata={2{store_data[15:0]}}; sw wstrb=1111, wdata=store_data. Stores set out_we=0.
- Load: byte = rdata[8*off+:8], half = rdata[16*addr[1]+:16]; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
- MEM: mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata stable until ack. 16-bit counter counts cycles in MEM.

## Timing
- Non-memory op: accept cycle N → out_valid at N+1.
- Memory op: mem_req high from N+1; ack sampled at cycle M → mem_req low at M+1, out_valid at M+1 (ack in N+1 gives out_valid at N+2).
- Timeout: if counter reaches TIMEOUT_CYCLES with no ack, next cycle mem_req=0, DONE, exc 10, out_we=0. Ack in the same cycle as timeout wins (normal completion).
- DONE holds out_* stable until out_ready; out_valid deasserts next cycle unless a new non-memory op was accepted concurrently.
- mem_ack outside MEM ignored (late ack after timeout or reset discarded).
- rst in any state: next cycle IDLE, mem_req=0, out_valid=0, counter cleared; in-flight op dropped.

## Test plan
- addi result alu_value=0x0000_0042, rd=5, out_ready=1 → out_valid one cycle after accept, out_value=0x42, out_rd=5, out_we=1, exc 00.
- lb addr 0x1003, mem_rdata=0x80FF_0000 acked after 3 wait cycles → mem_addr=0x1000, wstrb=0, out_value=0xFFFF_FF80; lbu same → 0x0000_0080.
- sh addr 0x2002, store_data=0x1234_ABCD → mem_we=1, wstrb=1100, wdata=0xABCD_ABCD, out_we=0.
- lw addr 0x3001 → no mem_req, out_exc=01, out_we=0; funct3 011 load → exc 11.
- TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then exc 10; repeat with ack on 4th cycle → normal result.
- Back-to-back addi stream with out_ready toggling 1/0 → no result lost or duplicated; rst asserted mid-MEM → mem_req low next cycle, later ack ignored.
